neuromorphic_x1_wb_master: RTL and testbench
============================================

Name: neuromorphic_x1_wb_master

Overview:
- Wishbone initiator that drives the Neuromorphic_X1 single-address command port (0x3000_000C) from a simple valid/ready request interface.
- Packs PROGRAM and READ commands into 32-bit command words and issues them as Wishbone writes.
- For READs, polls with Wishbone reads until a real result replaces the 0xDEAD_C0DE empty marker, then returns the stored bit.
- Sits between a host or controller engine and the Neuromorphic_X1_wb shim.

Parameters:
- ADDR, 32'h3000_000C, Wishbone address placed on every cycle.
- ACK_TIMEOUT, 16, maximum cycles with cyc/stb high before an ack is considered lost.
- POLL_GAP, 8, idle cycles between consecutive poll reads.
- MAX_POLL, 1024, poll reads allowed per READ before giving up (covers 32 queued programs × 200 cycles).

Ports:
- wb_clk_i  in  1  Wishbone clock.
- wb_rst_ni  in  1  Reset: asynchronous, active-low.
- req_valid_i  in  1  Request offered.
- req_ready_o  out  1  Request accepted when valid & ready.
- req_op_i  in  1  1 = PROGRAM, 0 = READ.
- req_row_i  in  5  Array row.
- req_col_i  in  5  Array column.
- req_data_i  in  8  PROGRAM value; core thresholds at >0x7F; ignored for READ.
- rsp_valid_o  out  1  One-cycle completion pulse.
- rsp_op_o  out  1  Op of the completed request.
- rsp_bit_o  out  1  READ result bit; 0 for PROGRAM.
- rsp_err_o  out  2  00 ok, 01 ack timeout, 10 poll exhausted, 11 malformed read data.
- busy_o  out  1  High whenever the FSM is not IDLE.
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone master controls.
- wbm_sel_o  out  4  Always 4'hF while cyc is high; 0 otherwise.
- wbm_adr_o  out  32  ADDR while cyc is high; 0 otherwise.
- wbm_dat_o  out  32  Command word.
- wbm_dat_i  in  32  Read data.
- wbm_ack_i  in  1  Slave acknowledge.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counters 0.
- Reset is asynchronous and active-low: asserting wb_rst_ni mid-cycle drops cyc/stb immediately. No response is emitted for the aborted request.
- Command word layout:
  - [31:30] = 2'b11 PROGRAM, 2'b01 READ
  - [29:25] = row
  - [24:20] = col
  - [19:8] = 0
  - [7:0] = data for PROGRAM, 0 for READ
- FSM states: IDLE, CMD_WR, POLL_GAP_ST, POLL_RD, RESP.
- IDLE:
  - req_ready_o = 1.
  - On accept, latch the request, build the command word, go to CMD_WR next cycle.
- CMD_WR:
  - cyc = stb = we = 1, dat_o = command word, held stable until ack.
  - On ack: PROGRAM goes to RESP with err 00; READ goes to POLL_GAP_ST with poll_cnt = 0.
- POLL_GAP_ST:
  - cyc = stb = 0 for POLL_GAP cycles, then POLL_RD.
  - This guarantees stb is low for at least one cycle between transfers, because the slave will not ack back-to-back.
- POLL_RD: cyc = stb = 1, we = 0. On ack, sample wbm_dat_i:
  - 0x0000_0000 or 0x0000_0001: go to RESP with rsp_bit = dat[0], err 00.
  - 0xDEAD_C0DE: increment poll_cnt. If poll_cnt reaches MAX_POLL, go to RESP with err 10; otherwise go to POLL_GAP_ST.
  - Any other value: go to RESP with err 11 and rsp_bit 0.
- Ack timeout (CMD_WR and POLL_RD):
  - Counter clears on entering the state.
  - When it reaches ACK_TIMEOUT with no ack, drop cyc/stb and go to RESP with err 01.
- RESP: rsp_valid_o is high for exactly one cycle, then IDLE. req_ready_o is low in every state except IDLE.
- Latency: PROGRAM with a 1-cycle ack slave gives rsp_valid 3 cycles after accept (accept → CMD_WR → ack → RESP).
- wbm_ack_i is ignored while cyc is low. An ack in the same cycle as a timeout expiry counts as a success.
- Exactly one request is in flight at a time. Ordering relative to the core's FIFO is therefore preserved: a READ after a PROGRAM to the same cell observes the programmed value.
- Counter widths are $clog2(parameter+1); no wrap is possible before the limit check.

Decomposition:
- Package neuromorphic_x1_pkg holds:
  - MODE_PROGRAM = 2'b11, MODE_READ = 2'b01
  - EMPTY_MARKER = 32'hDEAD_C0DE
  - DEFAULT_ADDR = 32'h3000_000C
  - field bit positions
  - rsp_err encodings
  - FSM state enum
- One natural sub-module: neuromorphic_x1_wb_xfer.
  - Performs a single Wishbone cycle with ack timeout.
  - Inputs: start, we, dat.
  - Outputs: done, rdata, timeout.
  - The top FSM sequences it for both the command write and the poll reads.

Test Plan:
- PROGRAM row 3, col 7, data 0xFF against the behavioural core → wbm_dat_o = 0xC670_00FF, one write ack, rsp_valid with err 00 within 3 cycles.
- PROGRAM (3, 7, 0xFF), then READ (3, 7) → READ write word 0x4670_0000; polls return DEAD_C0DE until about 244 cycles; rsp_bit = 1, err 00.
- PROGRAM (0, 0, 0x7F), then READ (0, 0) → rsp_bit = 0, confirming the threshold. stb must be low for ≥1 cycle between every transfer.
- Slave model that never acks → cyc drops after 16 cycles; rsp_err = 01; req_ready returns to 1.
- MAX_POLL = 4 with a slave that always returns DEAD_C0DE → exactly 4 poll reads, then rsp_err = 10. A slave returning 0x1234_5678 → rsp_err = 11.
- Reset asserted mid-POLL_RD → cyc/stb/rsp_valid go to 0 asynchronously; after release, IDLE with req_ready = 1 and no spurious response.

Source files
------------

// File: rtl/neuromorphic_x1_pkg.sv
// ============================================================================
// Module   : neuromorphic_x1_pkg
// Brief    : Shared constants, command-word layout and FSM state type for the
//            Neuromorphic_X1 Wishbone initiator.
// Revision : 1.0
// ============================================================================
`default_nettype none

package neuromorphic_x1_pkg;

    localparam logic [1:0]  MODE_PROGRAM = 2'b11;
    localparam logic [1:0]  MODE_READ    = 2'b01;

    localparam logic [31:0] EMPTY_MARKER = 32'hDEAD_C0DE;
    localparam logic [31:0] DEFAULT_ADDR = 32'h3000_000C;

    localparam int MODE_LSB = 30;
    localparam int ROW_LSB  = 25;
    localparam int COL_LSB  = 20;
    localparam int DATA_LSB = 0;
    localparam int ROW_W    = 5;
    localparam int COL_W    = 5;
    localparam int DATA_W   = 8;

    localparam logic [1:0] ERR_OK             = 2'b00;
    localparam logic [1:0] ERR_ACK_TIMEOUT    = 2'b01;
    localparam logic [1:0] ERR_POLL_EXHAUSTED = 2'b10;
    localparam logic [1:0] ERR_MALFORMED      = 2'b11;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        CMD_WR      = 3'd1,
        POLL_GAP_ST = 3'd2,
        POLL_RD     = 3'd3,
        RESP        = 3'd4
    } state_t;

    // READ commands carry a zero data byte; the core ignores it anyway.
    function automatic logic [31:0] build_cmd(
        input logic              op,
        input logic [ROW_W-1:0]  row,
        input logic [COL_W-1:0]  col,
        input logic [DATA_W-1:0] data
    );
        logic [31:0] w;
        w                      = '0;
        w[MODE_LSB +: 2]       = op ? MODE_PROGRAM : MODE_READ;
        w[ROW_LSB +: ROW_W]    = row;
        w[COL_LSB +: COL_W]    = col;
        w[DATA_LSB +: DATA_W]  = op ? data : '0;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/neuromorphic_x1_wb_xfer.sv
// ============================================================================
// Module   : neuromorphic_x1_wb_xfer
// Brief    : Single Wishbone classic cycle with ack timeout; done/timeout are
//            one-cycle pulses issued after the cycle ends.
// Revision : 1.0
// ============================================================================
`default_nettype none

module neuromorphic_x1_wb_xfer
    import neuromorphic_x1_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
)(
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        start,
    input  logic        we,
    input  logic [31:0] dat,
    output logic        done,
    output logic        timeout,
    output logic [31:0] rdata,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    localparam int                 c_CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(ACK_TIMEOUT - 1);

    logic               r_cyc;
    logic               r_we;
    logic               r_done;
    logic               r_timeout;
    logic [31:0]        r_dat;
    logic [31:0]        r_rdata;
    logic [c_CNT_W-1:0] r_cnt;

    // Ack is only honoured while cyc is high and wins over a same-cycle expiry.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_cyc     <= 1'b0;
            r_we      <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_dat     <= '0;
            r_rdata   <= '0;
            r_cnt     <= '0;
        end else begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            if (!r_cyc) begin
                if (start) begin
                    r_cyc <= 1'b1;
                    r_we  <= we;
                    r_dat <= dat;
                    r_cnt <= '0;
                end
            end else if (wbm_ack_i) begin
                r_cyc   <= 1'b0;
                r_we    <= 1'b0;
                r_done  <= 1'b1;
                r_rdata <= wbm_dat_i;
            end else if (r_cnt == c_CNT_LAST) begin
                r_cyc     <= 1'b0;
                r_we      <= 1'b0;
                r_timeout <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign done      = r_done;
    assign timeout   = r_timeout;
    assign rdata     = r_rdata;
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_cyc;
    assign wbm_we_o  = r_we;
    assign wbm_dat_o = r_dat;

endmodule

`default_nettype wire

// File: rtl/neuromorphic_x1_wb_master.sv
// ============================================================================
// Module   : neuromorphic_x1_wb_master
// Brief    : Valid/ready request front end that writes PROGRAM/READ commands
//            to the Neuromorphic_X1 port and polls for READ results.
// Revision : 1.0
// ============================================================================
`default_nettype none

module neuromorphic_x1_wb_master
    import neuromorphic_x1_pkg::*;
#(
    parameter logic [31:0] ADDR        = DEFAULT_ADDR,
    parameter int          ACK_TIMEOUT = 16,
    parameter int          POLL_GAP    = 8,
    parameter int          MAX_POLL    = 1024
)(
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_op_i,
    input  logic [4:0]  req_row_i,
    input  logic [4:0]  req_col_i,
    input  logic [7:0]  req_data_i,
    output logic        rsp_valid_o,
    output logic        rsp_op_o,
    output logic        rsp_bit_o,
    output logic [1:0]  rsp_err_o,
    output logic        busy_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    localparam int                  c_GAP_W     = $clog2(POLL_GAP + 1);
    localparam int                  c_POLL_W    = $clog2(MAX_POLL + 1);
    localparam logic [c_GAP_W-1:0]  c_GAP_LAST  = c_GAP_W'(POLL_GAP - 1);
    localparam logic [c_POLL_W-1:0] c_POLL_LAST = c_POLL_W'(MAX_POLL - 1);

    state_t              r_state;
    logic                r_ready;
    logic                r_op;
    logic                r_rsp_valid;
    logic                r_rsp_op;
    logic                r_rsp_bit;
    logic [1:0]          r_rsp_err;
    logic [31:0]         r_cmd;
    logic [c_GAP_W-1:0]  r_gap;
    logic [c_POLL_W-1:0] r_poll;

    logic                w_accept;
    logic                w_gap_done;
    logic                w_fin;
    logic                w_fin_bit;
    logic [1:0]          w_fin_err;
    logic [31:0]         w_cmd_new;
    logic                w_done;
    logic                w_timeout;
    logic                w_cyc;
    logic [31:0]         w_rdata;

    assign w_accept   = (r_state == IDLE) && req_valid_i && r_ready;
    assign w_gap_done = (r_state == POLL_GAP_ST) && (r_gap == c_GAP_LAST);
    assign w_cmd_new  = build_cmd(req_op_i, req_row_i, req_col_i, req_data_i);

    // The command write launches on the accept edge so cyc rises with CMD_WR.
    neuromorphic_x1_wb_xfer #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_xfer (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_ni (wb_rst_ni),
        .start     (w_accept | w_gap_done),
        .we        (w_accept),
        .dat       (w_accept ? w_cmd_new : r_cmd),
        .done      (w_done),
        .timeout   (w_timeout),
        .rdata     (w_rdata),
        .wbm_cyc_o (w_cyc),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i)
    );

    // Decide whether the transfer that just ended completes the request.
    always_comb begin
        w_fin     = 1'b0;
        w_fin_bit = 1'b0;
        w_fin_err = ERR_OK;
        if ((r_state == CMD_WR || r_state == POLL_RD) && w_timeout) begin
            w_fin     = 1'b1;
            w_fin_err = ERR_ACK_TIMEOUT;
        end else if (r_state == CMD_WR && w_done && r_op) begin
            w_fin = 1'b1;
        end else if (r_state == POLL_RD && w_done) begin
            if (w_rdata[31:1] == 31'd0) begin
                w_fin     = 1'b1;
                w_fin_bit = w_rdata[0];
            end else if (w_rdata == EMPTY_MARKER) begin
                if (r_poll == c_POLL_LAST) begin
                    w_fin     = 1'b1;
                    w_fin_err = ERR_POLL_EXHAUSTED;
                end
            end else begin
                w_fin     = 1'b1;
                w_fin_err = ERR_MALFORMED;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state     <= IDLE;
            r_ready     <= 1'b0;
            r_op        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_op    <= 1'b0;
            r_rsp_bit   <= 1'b0;
            r_rsp_err   <= ERR_OK;
            r_cmd       <= '0;
            r_gap       <= '0;
            r_poll      <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_fin) begin
                r_state     <= RESP;
                r_rsp_valid <= 1'b1;
                r_rsp_op    <= r_op;
                r_rsp_bit   <= w_fin_bit;
                r_rsp_err   <= w_fin_err;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_ready <= !w_accept;
                        if (w_accept) begin
                            r_op    <= req_op_i;
                            r_cmd   <= w_cmd_new;
                            r_state <= CMD_WR;
                        end
                    end
                    CMD_WR: begin
                        if (w_done) begin
                            r_state <= POLL_GAP_ST;
                            r_gap   <= '0;
                            r_poll  <= '0;
                        end
                    end
                    POLL_GAP_ST: begin
                        if (w_gap_done) begin
                            r_state <= POLL_RD;
                        end else begin
                            r_gap <= r_gap + 1'b1;
                        end
                    end
                    POLL_RD: begin
                        // Only an empty-marker poll below the limit lands here.
                        if (w_done) begin
                            r_poll  <= r_poll + 1'b1;
                            r_gap   <= '0;
                            r_state <= POLL_GAP_ST;
                        end
                    end
                    RESP: begin
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign req_ready_o = r_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_op_o    = r_rsp_op;
    assign rsp_bit_o   = r_rsp_bit;
    assign rsp_err_o   = r_rsp_err;
    assign busy_o      = (r_state != IDLE);
    assign wbm_cyc_o   = w_cyc;
    assign wbm_sel_o   = w_cyc ? 4'hF : 4'h0;
    assign wbm_adr_o   = w_cyc ? ADDR : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_neuromorphic_x1_wb_master.sv
// ============================================================================
// Module   : tb_neuromorphic_x1_wb_master
// Brief    : Self-checking bench with a behavioural Neuromorphic_X1 slave.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_neuromorphic_x1_wb_master;

    localparam logic [31:0] EMPTY    = 32'hDEAD_C0DE;
    localparam int          PROG_CYC = 200;
    localparam int          READ_CYC = 40;
    localparam int          BUDGET   = 20000;
    localparam int          M_NORMAL = 0;
    localparam int          M_NOACK  = 1;
    localparam int          M_GARBAGE = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0, req_op = 1'b0;
    logic [4:0]  req_row = '0, req_col = '0;
    logic [7:0]  req_data = '0;
    logic        req_ready, rsp_valid, rsp_op, rsp_bit, busy;
    logic [1:0]  rsp_err;
    logic        wbm_cyc, wbm_stb, wbm_we;
    logic [3:0]  wbm_sel;
    logic [31:0] wbm_adr, wbm_dat_o;
    logic        s_ack = 1'b0;
    logic [31:0] s_dat = '0;

    neuromorphic_x1_wb_master dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_row_i(req_row), .req_col_i(req_col), .req_data_i(req_data),
        .rsp_valid_o(rsp_valid), .rsp_op_o(rsp_op), .rsp_bit_o(rsp_bit),
        .rsp_err_o(rsp_err), .busy_o(busy),
        .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb), .wbm_we_o(wbm_we),
        .wbm_sel_o(wbm_sel), .wbm_adr_o(wbm_adr), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(s_dat), .wbm_ack_i(s_ack)
    );

    // Second instance with a tiny poll budget against an always-empty slave.
    logic        b_valid = 1'b0;
    logic        b_ready, b_rsp_valid, b_rsp_op, b_rsp_bit, b_busy;
    logic [1:0]  b_rsp_err;
    logic        b_cyc, b_stb, b_we;
    logic [3:0]  b_sel;
    logic [31:0] b_adr, b_dat_o;
    logic        b_ack = 1'b0;
    logic [31:0] b_rdat = '0;
    int          b_rd = 0;

    neuromorphic_x1_wb_master #(.MAX_POLL(4)) dut_b (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .req_valid_i(b_valid), .req_ready_o(b_ready), .req_op_i(1'b0),
        .req_row_i(5'd9), .req_col_i(5'd4), .req_data_i(8'h00),
        .rsp_valid_o(b_rsp_valid), .rsp_op_o(b_rsp_op), .rsp_bit_o(b_rsp_bit),
        .rsp_err_o(b_rsp_err), .busy_o(b_busy),
        .wbm_cyc_o(b_cyc), .wbm_stb_o(b_stb), .wbm_we_o(b_we),
        .wbm_sel_o(b_sel), .wbm_adr_o(b_adr), .wbm_dat_o(b_dat_o),
        .wbm_dat_i(b_rdat), .wbm_ack_i(b_ack)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural core: serial command execution, results visible after delay.
    int          slave_mode = M_NORMAL;
    int          now_cyc = 0, core_free = 0, res_time = 0;
    bit          res_pend = 1'b0, res_val = 1'b0;
    bit          core_mem [32][32];
    int          wr_count = 0, rd_count = 0;
    logic [31:0] last_word = '0;

    always @(posedge clk) begin : slave_a
        logic [4:0] r, c;
        now_cyc++;
        if (!rst_n) begin
            s_ack <= 1'b0;
        end else if (wbm_cyc && wbm_stb && !s_ack && slave_mode != M_NOACK) begin
            s_ack <= 1'b1;
            chk("wb_addr", wbm_adr, 32'h3000_000C);
            chk("wb_sel", wbm_sel, 4'hF);
            if (wbm_we) begin
                wr_count++;
                last_word = wbm_dat_o;
                r = wbm_dat_o[29:25];
                c = wbm_dat_o[24:20];
                if (wbm_dat_o[31:30] == 2'b11) begin
                    core_free = ((now_cyc > core_free) ? now_cyc : core_free) + PROG_CYC;
                    core_mem[r][c] = (wbm_dat_o[7:0] > 8'd127);
                end else if (wbm_dat_o[31:30] == 2'b01) begin
                    res_time  = ((now_cyc > core_free) ? now_cyc : core_free) + READ_CYC;
                    core_free = res_time;
                    res_val   = core_mem[r][c];
                    res_pend  = 1'b1;
                end
            end else begin
                rd_count++;
                if (slave_mode == M_GARBAGE) begin
                    s_dat <= 32'h1234_5678;
                end else if (res_pend && now_cyc >= res_time) begin
                    s_dat    <= {31'd0, res_val};
                    res_pend = 1'b0;
                end else begin
                    s_dat <= EMPTY;
                end
            end
        end else begin
            s_ack <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            b_ack <= 1'b0;
        end else if (b_cyc && b_stb && !b_ack) begin
            b_ack  <= 1'b1;
            b_rdat <= EMPTY;
            if (!b_we) b_rd++;
        end else begin
            b_ack <= 1'b0;
        end
    end

    int gap_viol = 0, cyc_hi_cnt = 0, rsp_cnt = 0;
    bit prev_ack = 1'b0;
    always @(negedge clk) begin
        if (prev_ack && wbm_stb) gap_viol++;
        prev_ack = s_ack;
        if (wbm_cyc) cyc_hi_cnt++;
        if (rsp_valid) rsp_cnt++;
    end

    bit ref_mem [32][32];

    function automatic logic [31:0] exp_word(input bit op, input int row, input int col, input int data);
        return ((op ? 32'd3 : 32'd1) << 30) | (32'(row) << 25) | (32'(col) << 20) | (op ? 32'(data) : 32'd0);
    endfunction

    task automatic run_req(input bit op, input logic [4:0] row, input logic [4:0] col,
                           input logic [7:0] data, output bit got, output logic rbit,
                           output logic [1:0] rerr, output logic rop, output int lat);
        int w;
        got = 1'b0; rbit = 1'b0; rerr = 2'b00; rop = 1'b0; lat = 0;
        w = 0;
        while (!req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("req_ready_wait", req_ready, 1'b1);
        if (!req_ready) return;
        req_valid = 1'b1; req_op = op; req_row = row; req_col = col; req_data = data;
        @(posedge clk);
        while (lat < BUDGET) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (rsp_valid) begin
                got = 1'b1; rbit = rsp_bit; rerr = rsp_err; rop = rsp_op;
                break;
            end
            lat++;
        end
        chk("rsp_seen", got, 1'b1);
        if (got) begin
            @(negedge clk);
            chk("rsp_pulse_one_cycle", rsp_valid, 1'b0);
            chk("ready_after_rsp", req_ready, 1'b1);
        end
    endtask

    typedef struct {
        bit          op;
        logic [4:0]  row;
        logic [4:0]  col;
        logic [7:0]  data;
        logic [31:0] word;
        bit          rbit;
    } vec_t;

    vec_t tbl [8];

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        bit          got;
        logic        rbit, rop;
        logic [1:0]  rerr;
        int          lat, wc0, rd0, ch0, rc0, k;
        bit          op, found;
        logic [4:0]  row, col;
        logic [7:0]  data;

        tbl[0] = '{1'b1, 5'd3,  5'd7,  8'hFF, 32'hC670_00FF, 1'b0};
        tbl[1] = '{1'b0, 5'd3,  5'd7,  8'h00, 32'h4670_0000, 1'b1};
        tbl[2] = '{1'b1, 5'd0,  5'd0,  8'h7F, 32'hC000_007F, 1'b0};
        tbl[3] = '{1'b0, 5'd0,  5'd0,  8'h00, 32'h4000_0000, 1'b0};
        tbl[4] = '{1'b1, 5'd31, 5'd31, 8'h80, 32'hFFF0_0080, 1'b0};
        tbl[5] = '{1'b0, 5'd31, 5'd31, 8'h00, 32'h7FF0_0000, 1'b1};
        tbl[6] = '{1'b1, 5'd31, 5'd31, 8'h00, 32'hFFF0_0000, 1'b0};
        tbl[7] = '{1'b0, 5'd31, 5'd31, 8'h00, 32'h7FF0_0000, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_ctrl", {req_ready, rsp_valid, rsp_op, rsp_bit, rsp_err, busy,
                           wbm_cyc, wbm_stb, wbm_we, wbm_sel}, '0);
        chk("reset_adr", wbm_adr, '0);
        chk("reset_dat", wbm_dat_o, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", req_ready, 1'b1);

        for (int i = 0; i < 8; i++) begin
            wc0 = wr_count;
            run_req(tbl[i].op, tbl[i].row, tbl[i].col, tbl[i].data, got, rbit, rerr, rop, lat);
            if (tbl[i].op) ref_mem[tbl[i].row][tbl[i].col] = (tbl[i].data > 8'd127);
            chk($sformatf("tbl[%0d] err", i), rerr, 2'b00);
            chk($sformatf("tbl[%0d] bit", i), rbit, tbl[i].rbit);
            chk($sformatf("tbl[%0d] op", i), rop, tbl[i].op);
            chk($sformatf("tbl[%0d] word", i), last_word, tbl[i].word);
            chk($sformatf("tbl[%0d] writes", i), wr_count - wc0, 1);
            if (tbl[i].op) chk($sformatf("tbl[%0d] prog_latency", i), lat, 3);
        end

        for (int i = 0; i < 24; i++) begin
            op   = bit'($urandom_range(0, 1));
            row  = 5'($urandom_range(0, 3));
            col  = 5'($urandom_range(0, 3));
            data = 8'($urandom_range(0, 255));
            wc0  = wr_count;
            run_req(op, row, col, data, got, rbit, rerr, rop, lat);
            chk($sformatf("rnd[%0d] err", i), rerr, 2'b00);
            chk($sformatf("rnd[%0d] op", i), rop, op);
            chk($sformatf("rnd[%0d] bit", i), rbit, op ? 1'b0 : ref_mem[row][col]);
            chk($sformatf("rnd[%0d] word", i), last_word, exp_word(op, row, col, data));
            chk($sformatf("rnd[%0d] writes", i), wr_count - wc0, 1);
            if (op) ref_mem[row][col] = (data > 8'd127);
        end

        slave_mode = M_NOACK;
        ch0 = cyc_hi_cnt;
        run_req(1'b1, 5'd2, 5'd2, 8'h55, got, rbit, rerr, rop, lat);
        chk("noack_err", rerr, 2'b01);
        chk("noack_cyc_high_cycles", cyc_hi_cnt - ch0, 16);
        slave_mode = M_NORMAL;

        slave_mode = M_GARBAGE;
        rd0 = rd_count;
        run_req(1'b0, 5'd1, 5'd1, 8'h00, got, rbit, rerr, rop, lat);
        chk("garbage_err", rerr, 2'b11);
        chk("garbage_bit", rbit, 1'b0);
        chk("garbage_polls", rd_count - rd0, 1);
        slave_mode = M_NORMAL;

        k = 0;
        while (!b_ready && k < 100) begin @(negedge clk); k++; end
        b_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_valid = 1'b0;
        found = 1'b0;
        for (int j = 0; j < 2000; j++) begin
            if (b_rsp_valid) begin found = 1'b1; break; end
            @(negedge clk);
        end
        chk("maxpoll_rsp_seen", found, 1'b1);
        chk("maxpoll_err", b_rsp_err, 2'b10);
        chk("maxpoll_reads", b_rd, 4);
        chk("maxpoll_op_bit", {b_rsp_op, b_rsp_bit}, 2'b00);

        run_req(1'b1, 5'd5, 5'd5, 8'hAA, got, rbit, rerr, rop, lat);
        k = 0;
        while (!req_ready && k < 100) begin @(negedge clk); k++; end
        req_valid = 1'b1; req_op = 1'b0; req_row = 5'd5; req_col = 5'd5;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        found = 1'b0;
        for (int j = 0; j < 2000; j++) begin
            if (wbm_cyc && !wbm_we) begin found = 1'b1; break; end
            @(negedge clk);
        end
        chk("poll_reached_before_reset", found, 1'b1);
        #1 rst_n = 1'b0;
        #1 chk("async_reset_drop", {wbm_cyc, wbm_stb, rsp_valid, busy}, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rc0 = rsp_cnt;
        repeat (40) @(negedge clk);
        chk("post_reset_ready", req_ready, 1'b1);
        chk("post_reset_idle", {busy, wbm_cyc}, 2'b00);
        chk("post_reset_no_rsp", rsp_cnt - rc0, 0);

        chk("stb_gap_violations", gap_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
